// File: rtl/store_buffer_if.sv
// store_buffer_if: core-side store/load port, RAM read/write ports and status of the store buffer.
interface store_buffer_if #(parameter int CNT_W = 3);
  logic mem_write;
  logic [31:0] data_addr_m;
  logic [31:0] write_data_m;
  logic [31:0] read_data_m;
  logic [31:0] ram_raddr;
  logic [31:0] ram_rdata;
  logic ram_wreq;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic ram_wack;
  logic full;
  logic empty;
  logic overflow;
  logic [CNT_W-1:0] count;
  modport master (
    output mem_write, data_addr_m, write_data_m, ram_rdata, ram_wack,
    input read_data_m, ram_raddr, ram_wreq, ram_waddr, ram_wdata, full, empty, overflow, count
  );
  modport slave (
    input mem_write, data_addr_m, write_data_m, ram_rdata, ram_wack,
    output read_data_m, ram_raddr, ram_wreq, ram_waddr, ram_wdata, full, empty, overflow, count
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: FIFO of word stores drained to RAM by req/ack, with store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CNT_W-1:0] cnt;
  logic ovf, full, empty, push, pop;
  logic [31:0] fwd;
  assign full = cnt == CNT_W'(DEPTH);
  assign empty = cnt == '0;
  assign push = sb.mem_write && !full;
  assign pop = !empty && sb.ram_wack;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (sb.mem_write && full) ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= sb.data_addr_m;
      data_q[tail] <= sb.write_data_m;
    end
  end
  // walk oldest to youngest so the last match wins
  always_comb begin
    fwd = sb.ram_rdata;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CNT_W'(i) < cnt && addr_q[idx][31:2] == sb.data_addr_m[31:2]) fwd = data_q[idx];
    end
  end
  assign sb.read_data_m = fwd;
  assign sb.ram_raddr = sb.data_addr_m;
  assign sb.ram_wreq = !empty;
  assign sb.ram_waddr = addr_q[head];
  assign sb.ram_wdata = data_q[head];
  assign sb.full = full;
  assign sb.empty = empty;
  assign sb.overflow = ovf;
  assign sb.count = cnt;
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the pipelined core's memory stage, between the core's data-side port and the dual-port data RAM.
- Accepts single-cycle word stores from the core (mem_write, data_addr_m, write_data_m) into a FIFO.
- Drains queued stores to the RAM write port with a req/ack handshake, so a slow RAM write port does not stall the M stage.
- Returns load data to the core through read_data_m, forwarding from queued stores that have not yet drained (store-to-load forwarding).

Parameters:
DEPTH, 4, number of store entries; power of two, ≥2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
mem_write  input  1  core M-stage store strobe, one store per asserted cycle
data_addr_m  input  32  core M-stage byte address (load or store)
write_data_m  input  32  core M-stage store data
read_data_m  output  32  load data to core (combinational)
ram_raddr  output  32  RAM read-port address (combinational, = data_addr_m)
ram_rdata  input  32  RAM read-port data, combinational w.r.t. ram_raddr
ram_wreq  output  1  head entry valid, write requested
ram_waddr  output  32  head entry address
ram_wdata  output  32  head entry data
ram_wack  input  1  RAM accepted head write this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a store arrived while full
count  output  CNT_W  current occupancy

Behaviour:
- Word granularity only. Addresses are compared and stored as given. Matching uses addr[31:2]; addr[1:0] is ignored for matching.
- Storage: circular FIFO with head pointer, tail pointer and count registers. Pointers wrap modulo DEPTH.
- Enqueue: when mem_write=1 and full=0 at the clock edge, write {data_addr_m, write_data_m} at tail, then tail+1.
- Full is evaluated on the registered count. A store while full is dropped even if ram_wack=1 the same cycle. The dropped store sets overflow=1, which holds until rst.
- Drain:
  - ram_wreq = !empty.
  - ram_waddr and ram_wdata = head entry. They are stable while ram_wreq=1 and no ack arrives.
  - Pop on the edge where ram_wreq=1 and ram_wack=1: head+1.
  - ram_wack while empty is ignored.
- Count update:
  - +1 on enqueue only.
  - −1 on pop only.
  - Unchanged on simultaneous enqueue and pop. This is legal whenever full=0, including empty→push+no-pop.
- Empty-to-RAM latency: a store enqueued at edge N appears on ram_wreq/ram_waddr/ram_wdata in cycle N+1. There is no same-cycle bypass.
- Forwarding (combinational):
  - Compare data_addr_m[31:2] against every valid entry.
  - If any entry matches, read_data_m = data of the youngest matching entry (closest to tail). Otherwise read_data_m = ram_rdata.
  - The head entry being acked this cycle is still valid and still participates in matching.
  - The store being enqueued in the current cycle does not participate.
- ram_raddr = data_addr_m at all times.
- Ordering: RAM writes occur in exact program order. Duplicate addresses are not merged.
- Reset:
  - head=0, tail=0, count=0, overflow=0.
  - empty=1, full=0, ram_wreq=0.
  - Reset asserted mid-drain discards all queued entries. An ack in the reset cycle is ignored.
- Entry data registers need no reset. Valid state is derived from head, tail and count only.

Test Plan:
- Reset, then idle → empty=1, full=0, count=0, ram_wreq=0, overflow=0; read_data_m tracks ram_rdata (drive 0xDEADBEEF, observe 0xDEADBEEF).
- Store 0x11111111 to 0x100 with ram_wack held 0 → next cycle ram_wreq=1, ram_waddr=0x100, ram_wdata=0x11111111, count=1. Load 0x100 with ram_rdata=0 → read_data_m=0x11111111. Load 0x102 → forwards the same word. Load 0x104 → ram_rdata.
- Stores 0xA to 0x200, then 0xB to 0x200, no acks → load 0x200 returns 0xB. Ack once → ram_wdata=0xB, still returns 0xB. Ack again → empty=1, returns ram_rdata.
- DEPTH=4: 5 back-to-back stores, no ack → full=1 after the 4th, 5th dropped, overflow=1, count=4. Then ack 4 cycles → RAM sees stores 1–4 in order, empty=1, overflow stays 1 until rst.
- Steady stream: store every cycle with ram_wack=1 every cycle starting one cycle after the first store → count stays 1, no overflow, RAM write order equals issue order across pointer wrap (≥10 stores).
- Fill 3 entries, assert rst for one cycle with ram_wack=1 → count=0, ram_wreq=0 next cycle. A subsequent store to 0x300 appears at ram_waddr=0x300 as the first write.
